// File: rtl/reset_ctrl_pio_pkg.sv
// Shared constants for reset_ctrl_pio: register word addresses, pulse FSM states
// and the PULSE-register bit that clears the sticky done flag.
package reset_ctrl_pio_pkg;
   localparam logic [2:0] ADDR_DATA      = 3'd0;
   localparam logic [2:0] ADDR_SET       = 3'd1;
   localparam logic [2:0] ADDR_CLR       = 3'd2;
   localparam logic [2:0] ADDR_PULSE     = 3'd3;
   localparam logic [2:0] ADDR_PULSE_LEN = 3'd4;
   localparam logic [2:0] ADDR_IRQ_CTRL  = 3'd5;

   localparam int DONE_CLR_BIT = 31;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;
endpackage

// File: rtl/reset_ctrl_pio_pulse_timer.sv
// Pulse length counter: loads on start, counts down to zero and holds there.
// zero tells the controlling FSM that the current cycle is the last pulse cycle.
module pulse_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);
   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= load_val;
      end else if (cnt_reg != '0) begin
         cnt_reg <= cnt_reg - CNT_W'(1);
      end
   end

   assign zero = (cnt_reg == '0);
endmodule

// File: rtl/reset_ctrl_pio.sv
// Avalon-MM driven reset/control line bank with SET/CLR and a timed pulse engine.
// Define RESET_CTRL_PIO_IRQ_EN to add the IRQ_CTRL register and the irq output.
module reset_ctrl_pio
   import reset_ctrl_pio_pkg::*;
#(
   parameter int              N_CH          = 4,
   parameter logic [N_CH-1:0] RESET_VAL     = N_CH'(4'hF),
   parameter int              CNT_W         = 16,
   parameter int              PULSE_LEN_DEF = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [2:0]      address,
   input  logic            chipselect,
   input  logic            write_n,
   input  logic [31:0]     writedata,
   output logic [31:0]     readdata,
   output logic [N_CH-1:0] out_port,
   output logic            busy
`ifdef RESET_CTRL_PIO_IRQ_EN
   ,
   output logic            irq
`endif
);
   state_t           state_reg, state_next;
   logic [N_CH-1:0]  data_reg, data_next;
   logic [N_CH-1:0]  mask_reg;
   logic [CNT_W-1:0] len_reg;
   logic [CNT_W-1:0] load_val;
   logic             done_reg, done_next;
   logic             wr, start, pulse_end, timer_zero;
   logic [N_CH-1:0]  wd_ch;
   logic             unused_wd;

   assign wr        = chipselect && !write_n;
   assign wd_ch     = writedata[N_CH-1:0];
   assign start     = wr && (address == ADDR_PULSE) && (state_reg == IDLE) && (wd_ch != '0);
   assign pulse_end = (state_reg == ACTIVE) && timer_zero;
   // A programmed length of 0 behaves like 1 so a pulse is never dropped.
   assign load_val  = (len_reg == '0) ? '0 : len_reg - CNT_W'(1);
   assign unused_wd = ^writedata;

   pulse_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (start),
      .load_val (load_val),
      .zero     (timer_zero)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start)     state_next = ACTIVE;
         ACTIVE:  if (timer_zero) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_reg == ACTIVE);
   end

   // Release clear is applied first so a same-edge DATA/SET write can re-raise bits.
   always_comb begin
      data_next = data_reg;
      if (pulse_end) data_next = data_next & ~mask_reg;
      if (wr) begin
         case (address)
            ADDR_DATA:  data_next = wd_ch;
            ADDR_SET:   data_next = data_next | wd_ch;
            ADDR_CLR:   data_next = data_next & ~wd_ch;
            ADDR_PULSE: if (start) data_next = data_next | wd_ch;
            default:    ;
         endcase
      end
   end

   always_comb begin
      done_next = done_reg;
      if (pulse_end)
         done_next = 1'b1;
      else if (start)
         done_next = 1'b0;
      else if (wr && (address == ADDR_PULSE) && (state_reg == IDLE) && writedata[DONE_CLR_BIT])
         done_next = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data_reg <= RESET_VAL;
         len_reg  <= CNT_W'(PULSE_LEN_DEF);
         mask_reg <= '0;
         done_reg <= 1'b0;
      end else begin
         data_reg <= data_next;
         done_reg <= done_next;
         if (start)          mask_reg <= wd_ch;
         else if (pulse_end) mask_reg <= '0;
         if (wr && (address == ADDR_PULSE_LEN)) len_reg <= writedata[CNT_W-1:0];
      end
   end

`ifdef RESET_CTRL_PIO_IRQ_EN
   logic irq_en_reg, irq_en_next;

   assign irq_en_next = (wr && (address == ADDR_IRQ_CTRL)) ? writedata[0] : irq_en_reg;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         irq_en_reg <= 1'b0;
         irq        <= 1'b0;
      end else begin
         irq_en_reg <= irq_en_next;
         irq        <= irq_en_next && done_next;
      end
   end
`endif

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:      readdata[N_CH-1:0]  = data_reg;
         ADDR_PULSE:     readdata[1:0]       = {done_reg, busy};
         ADDR_PULSE_LEN: readdata[CNT_W-1:0] = len_reg;
`ifdef RESET_CTRL_PIO_IRQ_EN
         ADDR_IRQ_CTRL:  readdata[0]         = irq_en_reg;
`endif
         default:        ;
      endcase
   end

   assign out_port = data_reg;
endmodule

// File: tb/tb_reset_ctrl_pio.sv
// Randomised self-checking bench for reset_ctrl_pio against a cycle-stamped model.
// Honours RESET_CTRL_PIO_IRQ_EN to exercise the irq path when defined.
module tb_reset_ctrl_pio;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [3:0]  out_port;
   logic        busy;
`ifdef RESET_CTRL_PIO_IRQ_EN
   logic        irq;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   // Model: pulse end is an absolute cycle stamp instead of a down-counter.
   int     cyc = 0;
   int     m_data, m_plen, m_mask, m_done, m_active, m_irq_en, m_end;

   always #5 clk = ~clk;

   reset_ctrl_pio dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port),
      .busy       (busy)
`ifdef RESET_CTRL_PIO_IRQ_EN
      ,
      .irq        (irq)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s cyc=%0d got=0x%08h exp=0x%08h", tag, cyc, got, exp);
      end
   endtask

   function automatic int model_read(input int a);
      case (a)
         0:       return m_data;
         3:       return (m_done << 1) | m_active;
         4:       return m_plen;
`ifdef RESET_CTRL_PIO_IRQ_EN
         5:       return m_irq_en;
`endif
         default: return 0;
      endcase
   endfunction

   task automatic model_edge(input bit rst, input bit w, input int a, input logic [31:0] d);
      int was_active;
      if (rst) begin
         m_data = 'hF; m_plen = 16; m_mask = 0; m_done = 0; m_active = 0; m_irq_en = 0;
         return;
      end
      was_active = m_active;
      if (m_active != 0 && cyc == m_end) begin
         m_data   = m_data & ~m_mask;
         m_active = 0;
         m_done   = 1;
      end
      if (w) begin
         case (a)
            0: m_data = d & 'hF;
            1: m_data = m_data | (d & 'hF);
            2: m_data = m_data & ~(d & 'hF);
            3: if (was_active == 0) begin
                  if ((d & 'hF) != 0) begin
                     m_mask   = d & 'hF;
                     m_data   = m_data | m_mask;
                     m_active = 1;
                     m_done   = 0;
                     m_end    = cyc + ((m_plen == 0) ? 1 : m_plen);
                  end else if (d[31]) begin
                     m_done = 0;
                  end
               end
            4: m_plen = d & 'hFFFF;
`ifdef RESET_CTRL_PIO_IRQ_EN
            5: m_irq_en = d & 1;
`endif
            default: ;
         endcase
      end
   endtask

   // One clock: drive the bus, update the model at the edge, then compare state and a random read.
   task automatic step(input bit rst, input bit w, input logic [2:0] a, input logic [31:0] d);
      logic [2:0] ra;
      reset_n    = !rst;
      chipselect = w;
      write_n    = !w;
      address    = a;
      writedata  = d;
      @(posedge clk);
      cyc++;
      model_edge(rst, w, int'(a), d);
      #1;
      reset_n    = 1'b1;
      chipselect = 1'b0;
      write_n    = 1'b1;
      check_val("out_port", 32'(out_port), m_data);
      check_val("busy", 32'(busy), m_active);
`ifdef RESET_CTRL_PIO_IRQ_EN
      check_val("irq", 32'(irq), ((m_irq_en != 0) && (m_done != 0)) ? 1 : 0);
`endif
      ra      = 3'($urandom_range(0, 7));
      address = ra;
      #1;
      check_val($sformatf("rd@%0d", ra), readdata, model_read(int'(ra)));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 3'd0, 32'h0);
   endtask

   task automatic read_at(input logic [2:0] a, output logic [31:0] v);
      address = a;
      #1;
      v = readdata;
   endtask

   initial begin
      logic [31:0] v;
      int          hi_cnt;
      reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;

      // 1: reset
      step(1, 0, 3'd0, 0);
      step(1, 0, 3'd0, 0);
      check_val("rst_out", 32'(out_port), 32'hF);
      read_at(3'd4, v); check_val("rst_len", v, 32'd16);
      read_at(3'd3, v); check_val("rst_pulse", v, 32'd0);

      // 2: DATA / SET / CLR
      step(0, 1, 3'd0, 32'h5); check_val("data_wr", 32'(out_port), 32'h5);
      step(0, 1, 3'd1, 32'h8); check_val("set_wr", 32'(out_port), 32'hD);
      step(0, 1, 3'd2, 32'h1); check_val("clr_wr", 32'(out_port), 32'hC);
      read_at(3'd1, v); check_val("rd_set0", v, 32'd0);
      read_at(3'd2, v); check_val("rd_clr0", v, 32'd0);

      // 3: three-cycle pulse
      step(0, 1, 3'd0, 32'h0);
      step(0, 1, 3'd4, 32'd3);
      step(0, 1, 3'd3, 32'h6);
      hi_cnt = 1;
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 3'd0, 0);
         if (out_port == 4'h6) hi_cnt++;
      end
      check_val("pulse3_len", hi_cnt, 32'd3);
      read_at(3'd3, v); check_val("pulse3_done", v, 32'h2);

      // 4: zero length acts as one; start while busy is ignored
      step(0, 1, 3'd4, 32'd0);
      step(0, 1, 3'd3, 32'h1); check_val("p0_hi", 32'(out_port), 32'h1);
      step(0, 0, 3'd0, 0);     check_val("p0_lo", 32'(out_port), 32'h0);
      step(0, 1, 3'd4, 32'd5);
      step(0, 1, 3'd3, 32'h1);
      step(0, 1, 3'd3, 32'h2); check_val("busy_ign", 32'(out_port[1]), 32'd0);
      idle(8);

      // 5: reset mid-pulse
      step(0, 1, 3'd4, 32'd10);
      step(0, 1, 3'd3, 32'h3);
      step(0, 0, 3'd0, 0);
      step(1, 0, 3'd0, 0);
      check_val("rst_mid_out", 32'(out_port), 32'hF);
      check_val("rst_mid_busy", 32'(busy), 32'd0);
      idle(14);
      check_val("rst_no_rel", 32'(out_port), 32'hF);

`ifdef RESET_CTRL_PIO_IRQ_EN
      // 6: irq enable, set by done, cleared by done-clear write
      step(0, 1, 3'd5, 32'h1);
      step(0, 1, 3'd4, 32'd2);
      step(0, 1, 3'd3, 32'h4);
      idle(3);
      check_val("irq_set", 32'(irq), 32'd1);
      step(0, 1, 3'd3, 32'h80000000);
      check_val("irq_clr", 32'(irq), 32'd0);
`else
      read_at(3'd5, v); check_val("rd_irqctl0", v, 32'd0);
`endif

      // Randomised traffic
      for (int i = 0; i < 1500; i++) begin
         int          r;
         bit          rst, w;
         logic [2:0]  a;
         logic [31:0] d;
         r   = int'($urandom_range(0, 199));
         rst = (r == 0);
         w   = !rst && (r < 110);
         a   = 3'($urandom_range(0, 7));
         d   = $urandom;
         if (a == 3'd4) d = 32'($urandom_range(0, 8)) | (d & 32'hFFF0_0000);
         if (a == 3'd3) d = 32'($urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'h0);
         step(rst, w, a, d);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/reset_ctrl_pio.md
Name: reset_ctrl_pio

Overview:
Parametrised Avalon-MM slave that drives a bank of reset/control lines from the controller CPU. It generalises the fixed 4-bit output register with three additions:
- configurable channel count and reset value
- atomic SET/CLR registers
- hardware-timed reset pulse engine that asserts a channel mask for a programmable number of cycles, then releases it

It sits on the CPU data bus; out_port feeds the reset inputs of the peripheral blocks.

Parameters:
N_CH, 4, number of output channels (1..32)
RESET_VAL, 4'hF, out_port value after reset; width N_CH
CNT_W, 16, width of the pulse length counter
PULSE_LEN_DEF, 16, reset value of the PULSE_LEN register

Ports:
clk  in  1  system clock
reset_n  in  1  reset; one clock; reset is synchronous and active-low
address  in  3  register word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, combinational from address
out_port  out  N_CH  control/reset lines
busy  out  1  pulse engine active

Behaviour:
- Write strobe: chipselect && !write_n. Reads have zero wait states; readdata is combinational from address.
- Unmapped addresses (6, 7) read 0; writes to them are ignored.
- Register map:
  - 0 DATA (rw): data_out.
  - 1 SET (wo, reads 0): data_out |= wd[N_CH-1:0].
  - 2 CLR (wo, reads 0): data_out &= ~wd.
  - 3 PULSE: write = start mask. Read = {30'b0, done, busy}.
  - 4 PULSE_LEN (rw): CNT_W bits; upper bits of wd ignored and read 0.
  - 5 IRQ_CTRL: present only with the optional feature, otherwise reads 0.
- Reset (synchronous, reset_n low at a clk edge):
  - data_out=RESET_VAL
  - PULSE_LEN=PULSE_LEN_DEF
  - state=IDLE, busy=0, done=0, cnt=0, mask=0
  - Applies mid-pulse: the pulse is aborted and out_port returns to RESET_VAL.
- FSM IDLE:
  - A write to PULSE with a nonzero mask M latches mask=M and sets data_out |= M in the same edge.
  - Load cnt = max(PULSE_LEN,1)-1; go to ACTIVE; busy=1; done=0.
  - A write to PULSE with M=0 is a no-op.
- FSM ACTIVE:
  - When cnt != 0: cnt decrements each cycle.
  - When cnt == 0 at an edge: data_out &= ~mask, busy=0, done=1, go to IDLE.
  - Masked bits are high for exactly max(PULSE_LEN,1) cycles, counted from the edge after the start write.
- Writes to PULSE while ACTIVE are ignored: no restart, mask unchanged.
- Writes to PULSE_LEN while ACTIVE update the register only; the running count is unaffected.
- DATA/SET/CLR writes during ACTIVE take effect immediately.
- At pulse end, masked bits are cleared regardless of intervening writes. Unmasked bits are never touched by the engine.
- Same-edge priority on data_out: pulse-end clear first, then the bus write. A DATA/SET write on the release edge wins for the bits it sets.
- done is sticky; it is cleared by a start or by a read-side-effect-free write of 1 to PULSE bit 31. Bit 31 is not part of the mask, so N_CH <= 31 when done-clear is used.
- out_port = data_out; busy = (state==ACTIVE).

Optional Feature:
RESET_CTRL_PIO_IRQ_EN
- Defined:
  - Adds output irq (1 bit).
  - IRQ_CTRL at address 5: bit0 = irq enable (rw, reset 0).
  - irq = enable && done, registered.
  - Clearing done (PULSE bit 31 write) deasserts irq on the next edge.
- Undefined:
  - No irq port.
  - Address 5 reads 0 and ignores writes.

Decomposition:
- Package reset_ctrl_pio_pkg: address constants (ADDR_DATA..ADDR_IRQ_CTRL), FSM state enum {IDLE, ACTIVE}, DONE_CLR_BIT=31.
- One sub-module is natural: pulse_timer (load/count/expire, CNT_W parameter). Register decode stays in the top.

Test Plan:
1. Reset: hold reset_n low 2 cycles -> out_port=4'hF, readdata@4=16, readdata@3=0, busy=0.
2. DATA write 0x5, SET 0x8, CLR 0x1 -> out_port 0x5, 0xD, 0xC; readdata@1 and readdata@2 = 0.
3. DATA=0, PULSE_LEN=3, PULSE write 0x6 -> out_port=0x6 for exactly 3 cycles, then 0x0; busy high for the same 3 cycles; readdata@3=0x2 afterwards.
4. PULSE_LEN=0, PULSE 0x1 -> bit0 high for 1 cycle. A second PULSE 0x2 issued while busy (PULSE_LEN=5) is ignored: bit1 stays 0.
5. Reset asserted on cycle 2 of a 10-cycle pulse of 0x3 -> next edge out_port=0xF, busy=0, no later release.
6. IRQ_EN build: enable=1, pulse completes -> irq=1. Write 0x80000000 to PULSE -> irq=0 next edge. Non-IRQ build: readdata@5=0.
